d7seg_disp_sched: RTL and testbench

Display-ownership scheduler for the MusicPlayer 4-digit seven-segment display. It generates the digit scan at a fixed slot rate and decides, frame by frame, which content owns the display:
- the always-present base value (elapsed time);
- a temporary track-number overlay;
- a temporary volume overlay.

Overlays are granted by priority, held for a programmable number of frames, and committed only at frame boundaries so a digit never shows mixed content. It sits between the player control logic and the BCD-to-segment decoder/pin drivers.

---
 rtl/d7seg_pkg.sv | 31 +++
 rtl/d7seg_scan_tick.sv | 39 +++
 rtl/d7seg_disp_sched.sv | 162 ++++++++++++++++
 tb/tb_d7seg_disp_sched.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/d7seg_pkg.sv
// d7seg_pkg: shared definitions for the MusicPlayer seven-segment display scheduler.
//   - src_t        : display owner codes (BASE / TRK / VOL), also the FSM state encoding
//   - DEC_D0..D3   : one-cold digit enables for digit indices 0..3
//   - DEC_BLANK    : all digits disabled
//   - dec_for()    : digit index -> one-cold enable
package d7seg_pkg;

  typedef enum logic [1:0] {
    SRC_BASE = 2'd0,
    SRC_TRK  = 2'd1,
    SRC_VOL  = 2'd2
  } src_t;

  localparam logic [3:0] DEC_D0    = 4'b1110;
  localparam logic [3:0] DEC_D1    = 4'b1101;
  localparam logic [3:0] DEC_D2    = 4'b1011;
  localparam logic [3:0] DEC_D3    = 4'b0111;
  localparam logic [3:0] DEC_BLANK = 4'b1111;

  function automatic logic [3:0] dec_for(input logic [1:0] s);
    logic [3:0] d;
    case (s)
      2'd0:    d = DEC_D0;
      2'd1:    d = DEC_D1;
      2'd2:    d = DEC_D2;
      default: d = DEC_D3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/d7seg_scan_tick.sv
// d7seg_scan_tick: digit-slot divider and digit counter.
// Parameters:
//   SCAN_DIV : clk cycles per digit slot
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   tick out  last cycle of the current slot (divider at SCAN_DIV-1)
//   sel  out  registered digit index 0..3, advances after each tick
//   fb   out  frame boundary: tick on the last digit (sel == 3)
module d7seg_scan_tick #(
  parameter int SCAN_DIV = 5000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [1:0] sel,
  output logic       fb
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_reg;

  assign tick = (div_reg == DW'(SCAN_DIV - 1));
  assign fb   = tick && (sel == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
      sel     <= 2'd0;
    end else if (tick) begin
      div_reg <= '0;
      sel     <= sel + 2'd1;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

endmodule

// File: rtl/d7seg_disp_sched.sv
// d7seg_disp_sched: display-ownership scheduler for the 4-digit seven-segment display.
// Chooses, frame by frame, whether the base value, a track overlay or a volume
// overlay owns the display; overlays switch only at frame boundaries.
// Optional build macro:
//   D7SEG_BLANK_LZ_EN : blank leading-zero digits 3..1 (digit 0 never blanked)
// Parameters:
//   SCAN_DIV    : clk cycles per digit slot
//   HOLD_FRAMES : frames an overlay stays visible after commit (>= 1)
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   base_val in   base content, 4 BCD nibbles, [3:0] rightmost, sampled live
//   trk_req  in   1-cycle pulse: request track overlay
//   trk_val  in   track content, captured with trk_req
//   vol_req  in   1-cycle pulse: request volume overlay
//   vol_val  in   volume content, captured with vol_req
//   sel      out  current digit index
//   dec      out  one-cold digit enable (4'b1111 = blanked)
//   nib      out  nibble for the current digit
//   src      out  current owner: 0 BASE, 1 TRK, 2 VOL
//   busy     out  high while an overlay owns the display
module d7seg_disp_sched
  import d7seg_pkg::*;
#(
  parameter int SCAN_DIV    = 5000,
  parameter int HOLD_FRAMES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base_val,
  input  logic        trk_req,
  input  logic [15:0] trk_val,
  input  logic        vol_req,
  input  logic [15:0] vol_val,
  output logic [1:0]  sel,
  output logic [3:0]  dec,
  output logic [3:0]  nib,
  output logic [1:0]  src,
  output logic        busy
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

  logic          tick;
  logic          fb;
  logic [1:0]    sel_next;

  src_t          state_reg, state_next;
  logic [HW-1:0] hold_reg, hold_next, hold_dec;
  logic          pend_trk_reg, pend_trk_next;
  logic          pend_vol_reg, pend_vol_next;
  logic [15:0]   trk_buf_reg, trk_buf_next;
  logic [15:0]   vol_buf_reg, vol_buf_next;
  logic [15:0]   word_next;
  logic [3:0]    dec_reg, dec_next;
  logic [3:0]    nib_reg, nib_next;
  logic          busy_reg;

  d7seg_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .sel  (sel),
    .fb   (fb)
  );

  // dec/nib are registered against the digit index that will be current
  // after this edge, so they always line up with sel.
  assign sel_next = tick ? sel + 2'd1 : sel;

  // Newest request value always wins.
  assign trk_buf_next = trk_req ? trk_val : trk_buf_reg;
  assign vol_buf_next = vol_req ? vol_val : vol_buf_reg;

  assign hold_dec = (hold_reg != '0) ? hold_reg - 1'b1 : hold_reg;

  // Next-state logic. Pending flags are only consumed from their registered
  // value, so a request landing on a boundary cycle waits for the next frame;
  // a fresh request in the same cycle as a clear keeps the flag set.
  always_comb begin
    state_next    = state_reg;
    hold_next     = hold_reg;
    pend_trk_next = pend_trk_reg | trk_req;
    pend_vol_next = pend_vol_reg | vol_req;
    if (fb) begin
      hold_next = hold_dec;
      if (pend_trk_reg) begin
        state_next    = SRC_TRK;
        hold_next     = HOLD_LOAD;
        pend_trk_next = trk_req;
      end else if (state_reg != SRC_TRK && pend_vol_reg) begin
        state_next    = SRC_VOL;
        hold_next     = HOLD_LOAD;
        pend_vol_next = vol_req;
      end else if (state_reg != SRC_BASE && hold_dec == '0) begin
        if (pend_vol_reg) begin
          state_next    = SRC_VOL;
          hold_next     = HOLD_LOAD;
          pend_vol_next = vol_req;
        end else begin
          state_next = SRC_BASE;
        end
      end
    end
  end

  always_comb begin
    word_next = base_val;
    case (state_next)
      SRC_TRK: word_next = trk_buf_next;
      SRC_VOL: word_next = vol_buf_next;
      default: word_next = base_val;
    endcase
  end

  assign nib_next = word_next[4*sel_next +: 4];

`ifdef D7SEG_BLANK_LZ_EN
  // lz[k]: nibbles k..3 of the outgoing word are all zero.
  logic [3:0] lz;
  assign lz[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign lz[gi] = (word_next[15:4*gi] == '0);
    end
  endgenerate
  assign dec_next = lz[sel_next] ? DEC_BLANK : dec_for(sel_next);
`else
  assign dec_next = dec_for(sel_next);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SRC_BASE;
      hold_reg     <= '0;
      pend_trk_reg <= 1'b0;
      pend_vol_reg <= 1'b0;
      trk_buf_reg  <= '0;
      vol_buf_reg  <= '0;
      dec_reg      <= DEC_D0;
      nib_reg      <= 4'h0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      pend_trk_reg <= pend_trk_next;
      pend_vol_reg <= pend_vol_next;
      trk_buf_reg  <= trk_buf_next;
      vol_buf_reg  <= vol_buf_next;
      dec_reg      <= dec_next;
      nib_reg      <= nib_next;
      busy_reg     <= (state_next != SRC_BASE);
    end
  end

  assign dec  = dec_reg;
  assign nib  = nib_reg;
  assign src  = state_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_d7seg_disp_sched.sv
// Directed bench for d7seg_disp_sched with SCAN_DIV=4, HOLD_FRAMES=3.
// k counts clock edges since the last reset edge; one frame = 16 cycles and
// state changes land on edges k = 16, 32, 48, ...
module tb_d7seg_disp_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] base_val = 16'h1234;
  logic        trk_req = 1'b0;
  logic [15:0] trk_val = 16'h0000;
  logic        vol_req = 1'b0;
  logic [15:0] vol_val = 16'h0000;
  logic [1:0]  sel;
  logic [3:0]  dec;
  logic [3:0]  nib;
  logic [1:0]  src;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int k = 0;

  always #5 clk = ~clk;

  d7seg_disp_sched #(.SCAN_DIV(4), .HOLD_FRAMES(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .base_val (base_val),
    .trk_req  (trk_req),
    .trk_val  (trk_val),
    .vol_req  (vol_req),
    .vol_val  (vol_val),
    .sel      (sel),
    .dec      (dec),
    .nib      (nib),
    .src      (src),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto_k(input int t);
    while (k < t) step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
    $display("check %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic chk_digit(input string tag, input logic [1:0] s, input logic [3:0] d,
                           input logic [3:0] n, input logic [1:0] o);
    chk({tag, ".sel"}, 16'(sel), 16'(s));
    chk({tag, ".dec"}, 16'(dec), 16'(d));
    chk({tag, ".nib"}, 16'(nib), 16'(n));
    chk({tag, ".src"}, 16'(src), 16'(o));
    chk({tag, ".busy"}, 16'(busy), 16'(o != 2'd0));
  endtask

  initial begin
    // Reset and free run with base 1234
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    k = 0;
    chk_digit("reset", 2'd0, 4'b1110, 4'h0, 2'd0);
    goto_k(1);  chk_digit("base_d0", 2'd0, 4'b1110, 4'h4, 2'd0);
    goto_k(4);  chk_digit("base_d1", 2'd1, 4'b1101, 4'h3, 2'd0);
    goto_k(8);  chk_digit("base_d2", 2'd2, 4'b1011, 4'h2, 2'd0);
    goto_k(12); chk_digit("base_d3", 2'd3, 4'b0111, 4'h1, 2'd0);

    // Track overlay requested mid-frame
    goto_k(13);
    trk_val = 16'h0007; trk_req = 1'b1;
    step();
    trk_req = 1'b0;
    goto_k(15); chk_digit("trk_wait", 2'd3, 4'b0111, 4'h1, 2'd0);
    goto_k(16); chk_digit("trk_d0", 2'd0, 4'b1110, 4'h7, 2'd1);
    goto_k(20); chk_digit("trk_d1", 2'd1, 4'b1101, 4'h0, 2'd1);
    goto_k(63); chk_digit("trk_last", 2'd3, 4'b0111, 4'h0, 2'd1);
    goto_k(64); chk_digit("trk_expire", 2'd0, 4'b1110, 4'h4, 2'd0);

    // Simultaneous requests: TRK first, then VOL, then BASE
    goto_k(70);
    trk_val = 16'h0002; vol_val = 16'h0050;
    trk_req = 1'b1; vol_req = 1'b1;
    step();
    trk_req = 1'b0; vol_req = 1'b0;
    goto_k(80);  chk_digit("both_trk", 2'd0, 4'b1110, 4'h2, 2'd1);
    goto_k(127); chk_digit("both_trk_end", 2'd3, 4'b0111, 4'h0, 2'd1);
    goto_k(128); chk_digit("both_vol", 2'd0, 4'b1110, 4'h0, 2'd2);
    goto_k(132); chk_digit("both_vol_d1", 2'd1, 4'b1101, 4'h5, 2'd2);
    goto_k(175); chk_digit("both_vol_end", 2'd3, 4'b0111, 4'h0, 2'd2);
    goto_k(176); chk_digit("both_base", 2'd0, 4'b1110, 4'h4, 2'd0);

    // Track preempts volume, then returns to BASE
    goto_k(180);
    vol_val = 16'h0050; vol_req = 1'b1;
    step();
    vol_req = 1'b0;
    goto_k(192); chk_digit("pre_vol", 2'd0, 4'b1110, 4'h0, 2'd2);
    goto_k(200);
    trk_val = 16'h0009; trk_req = 1'b1;
    step();
    trk_req = 1'b0;
    goto_k(207); chk_digit("pre_vol_hold", 2'd3, 4'b0111, 4'h0, 2'd2);
    goto_k(208); chk_digit("pre_trk", 2'd0, 4'b1110, 4'h9, 2'd1);
    goto_k(255); chk_digit("pre_trk_end", 2'd3, 4'b0111, 4'h0, 2'd1);
    goto_k(256); chk_digit("pre_base", 2'd0, 4'b1110, 4'h4, 2'd0);

    // Reset while in TRK with VOL pending
    goto_k(260);
    trk_val = 16'h0003; trk_req = 1'b1;
    step();
    trk_req = 1'b0;
    goto_k(272); chk_digit("rst_trk", 2'd0, 4'b1110, 4'h3, 2'd1);
    goto_k(280);
    vol_val = 16'h0060; vol_req = 1'b1;
    step();
    vol_req = 1'b0;
    goto_k(290);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_digit("rst_mid", 2'd0, 4'b1110, 4'h0, 2'd0);
    k = 0;
    goto_k(16); chk_digit("rst_novol_a", 2'd0, 4'b1110, 4'h4, 2'd0);
    goto_k(33); chk_digit("rst_novol_b", 2'd0, 4'b1110, 4'h4, 2'd0);

    // Leading-zero handling with base 0040
    goto_k(40);
    base_val = 16'h0040;
    goto_k(48); chk_digit("lz_d0", 2'd0, 4'b1110, 4'h0, 2'd0);
    goto_k(52); chk_digit("lz_d1", 2'd1, 4'b1101, 4'h4, 2'd0);
`ifdef D7SEG_BLANK_LZ_EN
    goto_k(56); chk_digit("lz_d2", 2'd2, 4'b1111, 4'h0, 2'd0);
    goto_k(60); chk_digit("lz_d3", 2'd3, 4'b1111, 4'h0, 2'd0);
`else
    goto_k(56); chk_digit("lz_d2", 2'd2, 4'b1011, 4'h0, 2'd0);
    goto_k(60); chk_digit("lz_d3", 2'd3, 4'b0111, 4'h0, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
